// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing unit for the 5-stage MIPS core. It produces the stage
// register enables and flushes and the PC source select. It resolves memory
// wait-states, taken branches, multi-cycle mul/div and load-use hazards. It
// also keeps a sticky memory-timeout flag and a saturating stall counter.
module pipe_hazard_ctrl #(
    parameter int MULDIV_CYCLES = 4,
    parameter int MEM_TIMEOUT   = 64,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             idex_MemRead,
    input  logic [4:0]       idex_rt,
    input  logic             idex_muldiv,
    input  logic             exmem_Branch,
    input  logic             exmem_zero,
    input  logic             mem_req,
    input  logic             mem_ready,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             idex_en,
    output logic             exmem_en,
    output logic             memwb_en,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             exmem_flush,
    output logic             memwb_flush,
    output logic             pc_src,
    output logic             muldiv_busy,
    output logic             muldiv_step,
    output logic             mem_err,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int              WAIT_W   = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ERR = WAIT_W'(MEM_TIMEOUT - 1);
    localparam logic [3:0]      MD_LOAD  = 4'(MULDIV_CYCLES - 1);
    localparam bit              MD_MULTI = (MULDIV_CYCLES > 1);

    typedef enum logic {RUN, MD_BUSY} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              mem_err_q, mem_err_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic mem_stall;
    logic branch_taken;
    logic load_use;

    // Hazard detection; the memory stall only exists while MEM holds a real instruction.
    always_comb begin
        mem_stall    = (state_q == RUN) && mem_req && !mem_ready;
        branch_taken = exmem_Branch && exmem_zero;
        load_use     = idex_MemRead && (idex_rt != 5'd0) &&
                       ((idex_rt == id_rs) || (idex_rt == id_rt));
    end

    // Prioritised control outputs and FSM next state; everything is forced idle under reset.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        memwb_flush = 1'b0;
        pc_src      = 1'b0;
        muldiv_busy = 1'b0;
        muldiv_step = 1'b0;
        state_d     = state_q;
        cnt_d       = cnt_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    // Freeze the front of the pipe and drain a bubble into WB.
                    memwb_en    = 1'b1;
                    memwb_flush = 1'b1;
                end else if (branch_taken) begin
                    // Younger instructions in IF/ID/EX are killed, so their hazards are moot.
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    {ifid_flush, idex_flush, exmem_flush}         = 3'b111;
                    pc_src = 1'b1;
                end else if (idex_muldiv && MD_MULTI) begin
                    exmem_en    = 1'b1;
                    exmem_flush = 1'b1;
                    muldiv_step = 1'b1;
                    cnt_d       = MD_LOAD;
                    state_d     = MD_BUSY;
                end else if (load_use) begin
                    // Hold PC and IF_ID for one cycle, inject a bubble into EX.
                    {idex_en, exmem_en, memwb_en} = 3'b111;
                    idex_flush = 1'b1;
                end else begin
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    muldiv_step = idex_muldiv && !MD_MULTI;
                end
            end
            MD_BUSY: begin
                muldiv_busy = 1'b1;
                muldiv_step = 1'b1;
                if (cnt_q > 4'd1) begin
                    exmem_en    = 1'b1;
                    exmem_flush = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end else begin
                    // Final step: let the finished result advance into EX_MEM.
                    {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
                    cnt_d   = 4'd0;
                    state_d = RUN;
                end
            end
            default: begin
                cnt_d   = 4'd0;
                state_d = RUN;
            end
        endcase
        if (!rst) begin
            {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b00000;
            {ifid_flush, idex_flush, exmem_flush, memwb_flush} = 4'b0000;
            pc_src      = 1'b0;
            muldiv_busy = 1'b0;
            muldiv_step = 1'b0;
        end
    end

    // Memory wait counter, sticky timeout flag and saturating stall counter.
    always_comb begin
        wait_cnt_d = '0;
        mem_err_d  = mem_err_q;
        if (mem_stall) begin
            wait_cnt_d = (wait_cnt_q != WAIT_MAX) ? wait_cnt_q + WAIT_W'(1) : wait_cnt_q;
            if (wait_cnt_q >= WAIT_ERR) begin
                mem_err_d = 1'b1;
            end
        end
        stall_d = stall_q;
        if (!pc_en && (stall_q != '1)) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= RUN;
            cnt_q      <= 4'd0;
            wait_cnt_q <= '0;
            mem_err_q  <= 1'b0;
            stall_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            wait_cnt_q <= wait_cnt_d;
            mem_err_q  <= mem_err_d;
            stall_q    <= stall_d;
        end
    end

    assign mem_err      = mem_err_q;
    assign stall_cycles = stall_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Central sequencing unit for the 5-stage MIPS pipeline.
- Drives the en_reg and flush controls of PC, IF_ID, ID_EX, EX_MEM and MEM_WB, and selects the PC source.
- Resolves four hazard classes:
  - memory wait-states
  - taken branches, resolved from the Branch and zero values held in EX_MEM
  - multi-cycle mul/div in EX
  - load-use in ID
- Also keeps a memory-timeout error flag and a stall performance counter.

Parameters:
MULDIV_CYCLES, 4, total EX-stage cycles of a mul/div instruction (legal range 1..15; 1 = single-cycle)
MEM_TIMEOUT, 64, number of consecutive memory-stall cycles before mem_err sets
CNT_W, 32, width of the stall_cycles counter

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-low reset (asserted when 0)
id_rs  in  5  rs field of the instruction in ID
id_rt  in  5  rt field of the instruction in ID
idex_MemRead  in  1  instruction in EX is a load
idex_rt  in  5  destination rt of the instruction in EX
idex_muldiv  in  1  instruction in EX is mul/div
exmem_Branch  in  1  Branch_out from EX_MEM
exmem_zero  in  1  zero_out from EX_MEM
mem_req  in  1  MemRead_out | MemWrite_out from EX_MEM
mem_ready  in  1  data memory completes its access this cycle
pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  register enables
ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1 each  load a bubble (all zero) on this edge
pc_src  out  1  1 = PC loads the branch target
muldiv_busy  out  1  high while in MD_BUSY
muldiv_step  out  1  EX mul/div unit advances one step
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  saturating count of cycles with pc_en=0

Behaviour:
- While rst=0:
  - all enables, flushes, pc_src, muldiv_step and muldiv_busy are 0.
  - On the clock edge: state <= RUN, cnt <= 0, wait_cnt <= 0, mem_err <= 0, stall_cycles <= 0.
- Control outputs are combinational from the current state and inputs, so they act on the same edge.
- State RUN. Priority, highest first:
  1. Memory stall (mem_req & !mem_ready):
     - pc/ifid/idex/exmem_en = 0; memwb_en = 1 with memwb_flush = 1.
     - wait_cnt++ (saturates at MEM_TIMEOUT). When wait_cnt reaches MEM_TIMEOUT-1 and the stall persists, mem_err <= 1; mem_err stays 1 until reset. The stall itself continues.
     - All lower-priority conditions are deferred.
  2. Taken branch (exmem_Branch & exmem_zero):
     - pc_src = 1; all enables = 1; ifid_flush = idex_flush = exmem_flush = 1.
     - idex_muldiv and load-use are ignored because those instructions are killed.
  3. Mul/div start (idex_muldiv and MULDIV_CYCLES > 1):
     - pc/ifid/idex_en = 0; exmem_en = 1 with exmem_flush = 1; muldiv_step = 1.
     - cnt <= MULDIV_CYCLES-1; next state MD_BUSY.
  4. Load-use (idex_MemRead, idex_rt != 0, and idex_rt equals id_rs or id_rt):
     - pc_en = ifid_en = 0; idex_en = 1 with idex_flush = 1.
     - Lasts exactly one cycle.
  5. Otherwise:
     - all enables = 1, no flushes.
     - idex_muldiv with MULDIV_CYCLES = 1 sets muldiv_step = 1.
- wait_cnt clears on any cycle with no memory stall.
- State MD_BUSY:
  - muldiv_busy = 1, muldiv_step = 1.
  - MEM holds a bubble, so exmem_Branch and mem_req are ignored.
  - If cnt > 1: same stall pattern as the mul/div start case; cnt <= cnt-1.
  - If cnt = 1 (final cycle): all enables = 1 with no flush, so the result is captured into EX_MEM; next state RUN; cnt <= 0.
  - A mul/div instruction therefore occupies EX for exactly MULDIV_CYCLES cycles.
- stall_cycles increments on every cycle (rst=1) with pc_en = 0 and saturates at all-ones.
- Reset asserted mid-MD_BUSY or mid-stall aborts the operation; the block is in RUN on the next cycle.

Test Plan:
1. Reset then free run: rst=0 for 2 cycles, then rst=1 with no hazards -> all enables are 1, flushes 0, and stall_cycles stays 0.
2. Load-use: idex_MemRead=1, idex_rt=5, id_rs=5 -> exactly 1 cycle with pc_en=ifid_en=0 and idex_flush=1; stall_cycles=1. Repeat with idex_rt=0 -> no stall.
3. Branch: exmem_Branch=1, exmem_zero=1 while idex_muldiv=1 -> pc_src=1, three flushes high, no MD_BUSY entry. With exmem_zero=0 -> no flush and the mul/div starts.
4. Mul/div, MULDIV_CYCLES=4: idex_muldiv=1 -> 3 stall cycles with exmem_flush=1, then 1 release cycle with exmem_en=1 and no flush; muldiv_busy high for cycles 2-4; stall_cycles=3.
5. Memory wait: mem_req=1, mem_ready=0 for 3 cycles concurrent with exmem_Branch/zero=1 and load-use -> 3 full stalls with memwb_flush=1, then branch flush on the fourth cycle when mem_ready=1.
6. Timeout, MEM_TIMEOUT=4: hold the memory stall for 6 cycles -> mem_err rises after the 4th stall cycle and remains 1 after mem_ready=1; cleared only by rst=0. Also assert rst=0 in the MD_BUSY cycle with cnt=2 -> RUN and muldiv_busy=0 the next cycle.
